// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_W   = 128;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    MISS_REQ = 2'd2,
    RESPOND  = 2'd3
  } state_e;

  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        w);
    return line[w*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side handshake bundle of the instruction cache.
interface icache_ctrl_if;
  import icache_pkg::*;

  logic                cpu_req;
  logic [31:0]         cpu_addr;
  logic                cpu_gnt;
  logic                cpu_valid;
  logic [WORD_W-1:0]   cpu_instr;
  logic                mem_req;
  logic [31:0]         mem_addr;
  logic                mem_valid;
  logic [LINE_W-1:0]   mem_line;

  // slave: the cache controller; master: fetch stage plus instruction memory
  modport slave (
    input  cpu_req, cpu_addr, mem_valid, mem_line,
    output cpu_gnt, cpu_valid, cpu_instr, mem_req, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, mem_valid, mem_line,
    input  cpu_gnt, cpu_valid, cpu_instr, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_array.sv
// Tag, data and valid storage: one write port, combinational read, flush-all.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 28 - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic              wr_set_valid,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  // flush wins over a same-cycle fill so the filled line stays invalid
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    assign valid_d[gi] = flush ? 1'b0 :
                         (wr_en && wr_set_valid && (wr_idx == IDX_W'(gi))) ? 1'b1 :
                         valid_q[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: lookup FSM, line-fill handshake, hit/miss counters.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  icache_ctrl_if.slave      bus,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  state_e            state_q, state_d;
  logic [31:2]       req_addr_q, req_addr_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              fill_flushed_q, fill_flushed_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;
  logic              hit_inc, miss_inc, fill_en;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              hit;
  logic              addr_lsb_unused;

  assign req_idx         = req_addr_q[OFFSET_W +: IDX_W];
  assign req_tag         = req_addr_q[31 -: TAG_W];
  assign addr_lsb_unused = ^bus.cpu_addr[1:0];

  icache_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .rd_idx       (req_idx),
    .rd_valid     (rd_valid),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .wr_en        (fill_en),
    .wr_set_valid (!fill_flushed_q && !flush),
    .wr_idx       (req_idx),
    .wr_tag       (req_tag),
    .wr_data      (bus.mem_line)
  );

  // a flush in the lookup cycle must make this lookup miss
  assign hit = rd_valid && !flush && (rd_tag == req_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.cpu_req) state_d = LOOKUP;
      LOOKUP:   state_d = hit ? RESPOND : MISS_REQ;
      MISS_REQ: if (bus.mem_valid) state_d = RESPOND;
      RESPOND:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_addr_d     = req_addr_q;
    instr_d        = instr_q;
    mem_addr_d     = mem_addr_q;
    fill_flushed_d = fill_flushed_q;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    fill_en        = 1'b0;
    case (state_q)
      IDLE: if (bus.cpu_req) req_addr_d = bus.cpu_addr[31:2];
      LOOKUP: begin
        if (hit) begin
          hit_inc = 1'b1;
          instr_d = word_sel(rd_data, req_addr_q[3:2]);
        end else begin
          miss_inc       = 1'b1;
          mem_addr_d     = {req_addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
          fill_flushed_d = 1'b0;
        end
      end
      MISS_REQ: begin
        // remember a flush seen while waiting so the returning line is not trusted
        if (flush) fill_flushed_d = 1'b1;
        if (bus.mem_valid) begin
          fill_en = 1'b1;
          instr_d = word_sel(bus.mem_line, req_addr_q[3:2]);
        end
      end
      default: ;
    endcase
  end

  assign hit_cnt_d  = hit_cnt_q + {31'd0, hit_inc};
  assign miss_cnt_d = miss_cnt_q + {31'd0, miss_inc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_addr_q     <= '0;
      instr_q        <= '0;
      mem_addr_q     <= '0;
      fill_flushed_q <= 1'b0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      req_addr_q     <= req_addr_d;
      instr_q        <= instr_d;
      mem_addr_q     <= mem_addr_d;
      fill_flushed_q <= fill_flushed_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
    end
  end

  always_comb begin
    bus.cpu_gnt   = rst_n && (state_q == IDLE);
    bus.cpu_valid = rst_n && (state_q == RESPOND);
    bus.mem_req   = rst_n && (state_q == MISS_REQ);
    bus.cpu_instr = instr_q;
    bus.mem_addr  = mem_addr_q;
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed and randomized fetch sequences checked against a line-address cache model.
module tb_icache_ctrl;

  localparam int LINES = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hit_cnt, miss_cnt;

  int checks = 0;
  int failures = 0;

  icache_ctrl_if bus();

  icache_ctrl #(.LINES(LINES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  // model: which line address each slot holds, plus event counts
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  logic [31:0] m_hits;
  logic [31:0] m_misses;
  logic [31:0] seed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  function automatic logic [127:0] mem_image(input logic [31:0] la);
    logic [127:0] img;
    if (la == 32'd0) return {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    img = '0;
    for (int w = 0; w < 4; w++)
      img = img | ({96'd0, ((la ^ seed) * 32'h9E3779B1) + 32'(w) * 32'h01010101} << (32 * w));
    return img;
  endfunction

  // fmode: 0 plain, 1 flush while waiting for the fill, 2 flush with mem_valid,
  //        3 flush in the lookup cycle, 4 stray mem_valid in the lookup cycle
  task automatic fetch(input logic [31:0] addr, input int delay, input int fmode);
    logic [31:0]  la;
    int           idx;
    int           w;
    bit           exp_hit;
    bit           fl_with_mv;
    logic [127:0] img;
    logic [31:0]  exp_word;

    la       = addr >> 4;
    idx      = int'(la % LINES);
    w        = int'((addr % 16) / 4);
    img      = mem_image(la);
    exp_word = 32'(img >> (32 * w));
    if (fmode == 3) model_clear();
    exp_hit  = m_valid[idx] && (m_line[idx] == la);

    chk("gnt_idle", {31'd0, bus.cpu_gnt}, 32'd1);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    tick();
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = $urandom;
    chk("gnt_lookup", {31'd0, bus.cpu_gnt}, 32'd0);
    chk("valid_lookup", {31'd0, bus.cpu_valid}, 32'd0);
    if (fmode == 3) flush = 1'b1;
    if (fmode == 4) begin
      bus.mem_valid = 1'b1;
      bus.mem_line  = {$urandom, $urandom, $urandom, $urandom};
    end
    tick();
    flush         = 1'b0;
    bus.mem_valid = 1'b0;

    if (exp_hit) begin
      m_hits++;
      chk("hit_valid", {31'd0, bus.cpu_valid}, 32'd1);
      chk("hit_memreq", {31'd0, bus.mem_req}, 32'd0);
      chk("hit_instr", bus.cpu_instr, exp_word);
    end else begin
      m_misses++;
      chk("miss_memreq", {31'd0, bus.mem_req}, 32'd1);
      chk("miss_memaddr", bus.mem_addr, la << 4);
      chk("miss_valid", {31'd0, bus.cpu_valid}, 32'd0);
      fl_with_mv = (fmode == 2) || (fmode == 1 && delay == 0);
      for (int k = 0; k < delay; k++) begin
        if (fmode == 1 && k == 0) flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("wait_memreq", {31'd0, bus.mem_req}, 32'd1);
        chk("wait_memaddr", bus.mem_addr, la << 4);
        chk("wait_valid", {31'd0, bus.cpu_valid}, 32'd0);
      end
      bus.mem_valid = 1'b1;
      bus.mem_line  = img;
      flush         = fl_with_mv;
      tick();
      bus.mem_valid = 1'b0;
      flush         = 1'b0;
      bus.mem_line  = {$urandom, $urandom, $urandom, $urandom};
      chk("fill_memreq", {31'd0, bus.mem_req}, 32'd0);
      chk("fill_valid", {31'd0, bus.cpu_valid}, 32'd1);
      chk("fill_instr", bus.cpu_instr, exp_word);
      if (fmode == 1 || fmode == 2) model_clear();
      m_line[idx]  = la;
      m_valid[idx] = !(fmode == 1 || fmode == 2);
    end
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_misses);
    tick();
    chk("after_valid", {31'd0, bus.cpu_valid}, 32'd0);
    chk("after_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
    chk("instr_hold", bus.cpu_instr, exp_word);
    $display("txn addr=0x%08h mode=%0d hit=%0d instr=0x%08h hits=%0d misses=%0d",
             addr, fmode, exp_hit, bus.cpu_instr, hit_cnt, miss_cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {31'd0, bus.cpu_gnt}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.cpu_valid}, 32'd0);
    chk({tag, "_memreq"}, {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_hitcnt"}, hit_cnt, 32'd0);
    chk({tag, "_misscnt"}, miss_cnt, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    int          fm;

    seed          = $urandom;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_line  = '0;
    model_clear();
    m_hits   = '0;
    m_misses = '0;

    // reset state
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    chk("reset_instr", bus.cpu_instr, 32'd0);
    chk("reset_memaddr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_gnt", {31'd0, bus.cpu_gnt}, 32'd1);

    // miss then hit in the same line, conflict eviction, flush during fill
    fetch(32'h0000_0004, 5, 0);
    chk("first_instr", bus.cpu_instr, 32'hBBBBBBBB);
    fetch(32'h0000_000C, 0, 0);
    chk("second_instr", bus.cpu_instr, 32'hDDDDDDDD);
    fetch(32'h0000_0080, 2, 0);
    fetch(32'h0000_0000, 1, 0);
    chk("evict_misses", miss_cnt, 32'd3);
    fetch(32'h0000_0100, 3, 1);
    fetch(32'h0000_0100, 2, 0);

    // reset two cycles into a fill, then a late mem_valid
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0200;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    chk("midfill_memreq", {31'd0, bus.mem_req}, 32'd1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midfill_reset");
    rst_n         = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_line  = mem_image(32'h20);
    tick();
    bus.mem_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("late_valid", {31'd0, bus.cpu_valid}, 32'd0);
      chk("late_memreq", {31'd0, bus.mem_req}, 32'd0);
      chk("late_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
      tick();
    end
    chk("late_hitcnt", hit_cnt, 32'd0);
    chk("late_misscnt", miss_cnt, 32'd0);
    model_clear();
    m_hits   = '0;
    m_misses = '0;
    $display("txn reset mid-fill addr=0x00000200 gnt=%0d", bus.cpu_gnt);

    // hit counter wrap
    fetch(32'h0000_0040, 1, 0);
    force dut.hit_cnt_d = 32'hFFFF_FFFF;
    tick();
    release dut.hit_cnt_d;
    chk("preload_hitcnt", hit_cnt, 32'hFFFF_FFFF);
    m_hits = 32'hFFFF_FFFF;
    fetch(32'h0000_0044, 0, 0);
    chk("wrap_hitcnt", hit_cnt, 32'd0);

    // randomized traffic with conflicting tags and flush corner cases
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 23)) << 4) | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 1) == 1) a = a | 32'hABC0_0000;
      r  = int'($urandom_range(0, 9));
      fm = (r < 5) ? r : 0;
      fetch(a, int'($urandom_range(0, 4)), fm);
      if ($urandom_range(0, 7) == 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        chk("idle_flush_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        $display("txn idle flush");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache controller between the fetch stage and the slow line-wide instruction memory.
- Holds LINES x 128-bit lines with tags and valid bits, and returns 32-bit instructions on a hit.
- On a miss, issues one line-fill request to memory with a req/valid handshake and waits any number of cycles.
- Also provides a flush input and hit/miss event counters for performance measurement.

Parameters:
- LINES, 8, number of cache lines; power of two, 2..64.
- IDX_W, $clog2(LINES), index width; derived, not overridden.
- TAG_W, 28-IDX_W, tag width, taken from cpu_addr[31:4+IDX_W].

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  fetch request; sampled only when cpu_gnt=1.
- cpu_addr  in  32  byte address of the fetch; bits [1:0] ignored.
- cpu_gnt  out  1  controller can accept a request this cycle.
- cpu_valid  out  1  one-cycle pulse; cpu_instr is valid.
- cpu_instr  out  32  returned instruction.
- flush  in  1  invalidate all lines.
- mem_req  out  1  line-fill request; held high until mem_valid.
- mem_addr  out  32  line address {tag,idx,4'b0000}; stable while mem_req=1.
- mem_valid  in  1  memory returns line; single-cycle pulse.
- mem_line  in  128  line data; word w = mem_line[32w+31:32w], w = addr[3:2].
- hit_cnt  out  32  number of hits, wraps at 2^32.
- miss_cnt  out  32  number of misses, wraps at 2^32.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state goes to IDLE; all valid bits, hit_cnt and miss_cnt clear.
  - cpu_valid=0, mem_req=0, cpu_instr=0, mem_addr=0, cpu_gnt=0 during reset.
  - Tag and data arrays are not reset.
- States: IDLE, LOOKUP, MISS_REQ, RESPOND.
- IDLE:
  - cpu_gnt=1.
  - cpu_req=1 latches cpu_addr into req_addr and moves to LOOKUP.
- LOOKUP:
  - cpu_gnt=0.
  - Hit = valid[idx] and tag[idx]==req_addr tag.
  - On a hit: cpu_valid=1 next cycle (RESPOND), hit_cnt+1, instruction selected by req_addr[3:2].
  - On a miss: miss_cnt+1, mem_req=1 and mem_addr={req_addr[31:4],4'b0} from the next cycle, go to MISS_REQ.
- MISS_REQ:
  - mem_req stays high.
  - On mem_valid: write mem_line and the tag, set the valid bit, drop mem_req the same edge, go to RESPOND with the selected word from mem_line.
- RESPOND:
  - cpu_valid=1 and cpu_instr driven for exactly one cycle, then IDLE.
  - cpu_instr holds its value until the next response.
- Latency:
  - Hit: request accepted at edge N; cpu_valid high in cycle N+2. Throughput is one request per 3 cycles.
  - Miss: cpu_valid high 1 cycle after the mem_valid edge.
- mem_valid outside MISS_REQ is ignored and has no side effects.
- Flush:
  - Clears all valid bits at the edge, from any state.
  - If asserted in LOOKUP, the lookup sees cleared valids and misses.
  - If asserted in MISS_REQ, the fill completes and the response is returned, but the filled line is NOT marked valid.
  - flush and a mem_valid in the same cycle: the response is returned and the line is left invalid.
- Reset mid-fill:
  - mem_req drops at the reset edge and no response is issued.
  - A late mem_valid is ignored.
  - Memory must tolerate an abandoned request.
- Counters: wrap 0xFFFFFFFF -> 0 silently; flush does not clear them.
- cpu_req while cpu_gnt=0 is ignored; the requester must hold or reissue it.

Decomposition:
- Shared package (icache_pkg):
  - LINE_W=128, WORD_W=32, OFFSET_W=4.
  - state encoding constants IDLE/LOOKUP/MISS_REQ/RESPOND.
  - word-select function (line, addr[3:2]) -> word.
- Sub-module icache_array:
  - tag, data and valid storage.
  - single write port; combinational read by index.
  - flush-all input.
- icache_ctrl contains the FSM, handshake and counters.

Test Plan:
- Reset, then request 0x00000004 with memory returning 0x...DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA after 5 cycles -> mem_addr=0x00000000, cpu_instr=0xBBBBBBBB, miss_cnt=1.
- Immediately request 0x0000000C -> hit, cpu_valid exactly 2 cycles after grant, cpu_instr=0xDDDDDDDD, mem_req stays 0, hit_cnt=1.
- Request 0x00000080, which maps to the same index as 0x0 when LINES=8 -> miss and refill. A following request to 0x00000000 -> miss again (eviction); miss_cnt=3.
- Assert flush during MISS_REQ for 0x100 -> data is returned. A repeat request to 0x100 misses; mem_req is reissued with mem_addr=0x100.
- Pull rst_n low 2 cycles into a fill, then pulse mem_valid -> mem_req=0, no cpu_valid, counters=0, IDLE with cpu_gnt=1.
- Preload hit_cnt=0xFFFFFFFF by force, then one hit -> hit_cnt=0.
